// File: rtl/pong_graph_anim_pkg.sv
// Shared constants for the pong graphics generator: screen limits, object
// bounds, colours and the round-ball bitmap.
package pong_graph_anim_pkg;

    localparam logic [9:0] H_MAX = 10'd640;
    localparam logic [9:0] V_MAX = 10'd480;
    localparam logic [9:0] BAR_V = 10'd4;
    localparam logic [9:0] BALL_V = 10'd2;

    localparam logic [9:0] X_MAX = H_MAX - 10'd1;
    localparam logic [9:0] REFR_Y = V_MAX + 10'd1;

    localparam logic [9:0] WALL_X_L = 10'd32;
    localparam logic [9:0] WALL_X_R = 10'd35;
    localparam logic [9:0] BAR_X_L = 10'd600;
    localparam logic [9:0] BAR_X_R = 10'd603;
    localparam logic [9:0] BAR_Y_SIZE = 10'd72;
    localparam logic [9:0] BALL_SIZE = 10'd8;

    // bar may only step down while its bottom stays above this line
    localparam logic [9:0] BAR_Y_LIM = V_MAX - 10'd1 - BAR_V;
    localparam logic [9:0] BALL_Y_TOP_LIM = 10'd1;
    localparam logic [9:0] BALL_Y_BOT_LIM = V_MAX - 10'd2;

    localparam logic [9:0] BAR_Y_RST = 10'd204;
    localparam logic [9:0] BALL_X_RST = 10'd320;
    localparam logic [9:0] BALL_Y_RST = 10'd240;

    localparam logic [9:0] V_POS = BALL_V;
    localparam logic [9:0] V_NEG = 10'd0 - BALL_V;

    typedef enum logic [2:0] {
        RGB_OFF  = 3'b000,
        RGB_WALL = 3'b001,
        RGB_BAR  = 3'b010,
        RGB_BALL = 3'b100,
        RGB_BG   = 3'b110
    } rgb_t;

    // bit 7 of each row is the leftmost pixel
    function automatic logic [7:0] ball_row(input logic [2:0] row);
        logic [7:0] r;
        case (row)
            3'd0, 3'd7: r = 8'b0011_1100;
            3'd1, 3'd6: r = 8'b0111_1110;
            default:    r = 8'b1111_1111;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/pong_graph_anim_if.sv
// Sync-stage inputs, buttons and graphics outputs of the pong generator.
interface pong_graph_anim_if;
    logic       p_tick;
    logic       video_on;
    logic [9:0] pix_x;
    logic [9:0] pix_y;
    logic [1:0] btn;
    logic       miss;
    logic [2:0] graph_rgb;

    modport master (
        output p_tick, video_on, pix_x, pix_y, btn,
        input  miss, graph_rgb
    );

    modport slave (
        input  p_tick, video_on, pix_x, pix_y, btn,
        output miss, graph_rgb
    );
endinterface

// File: rtl/pong_graph_anim_rom.sv
// Combinational 8x8 round-ball bitmap, one row per lookup.
module pong_graph_anim_rom
    import pong_graph_anim_pkg::*;
(
    input  logic [2:0] row,
    output logic [7:0] data
);
    assign data = ball_row(row);
endmodule

// File: rtl/pong_graph_anim.sv
// Animated pong graphics: wall, button-driven paddle and bouncing ball,
// updated once per frame and rendered combinationally per pixel.
module pong_graph_anim
    import pong_graph_anim_pkg::*;
(
    input logic clk,
    input logic reset,
    pong_graph_anim_if.slave vif
);
    logic [9:0] bar_y_t, ball_x_l, ball_y_t, vx, vy;
    logic [9:0] bar_y_b, ball_x_r, ball_y_b;
    logic [9:0] vx_nxt, vy_nxt;
    logic       miss_r;
    logic       refr_tick;
    logic [2:0] rom_row, rom_col;
    logic [7:0] rom_data;
    logic       wall_on, bar_on, ball_box, ball_on;
    logic [2:0] rgb;

    assign refr_tick = vif.p_tick && (vif.pix_y == REFR_Y) && (vif.pix_x == 10'd0);

    assign bar_y_b  = bar_y_t + BAR_Y_SIZE - 10'd1;
    assign ball_x_r = ball_x_l + BALL_SIZE - 10'd1;
    assign ball_y_b = ball_y_t + BALL_SIZE - 10'd1;

    // velocities decided from the pre-update ball and bar positions
    always_comb begin
        vy_nxt = vy;
        if (ball_y_t <= BALL_Y_TOP_LIM)
            vy_nxt = V_POS;
        else if (ball_y_b >= BALL_Y_BOT_LIM)
            vy_nxt = V_NEG;

        vx_nxt = vx;
        if (ball_x_l <= WALL_X_R)
            vx_nxt = V_POS;
        else if (ball_x_r >= BAR_X_L && ball_x_r <= BAR_X_R &&
                 ball_y_b >= bar_y_t && ball_y_t <= bar_y_b)
            vx_nxt = V_NEG;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bar_y_t  <= BAR_Y_RST;
            ball_x_l <= BALL_X_RST;
            ball_y_t <= BALL_Y_RST;
            vx       <= V_POS;
            vy       <= V_POS;
            miss_r   <= 1'b0;
        end else begin
            miss_r <= 1'b0;
            if (refr_tick) begin
                if (vif.btn == 2'b10 && bar_y_b < BAR_Y_LIM)
                    bar_y_t <= bar_y_t + BAR_V;
                else if (vif.btn == 2'b01 && bar_y_t > BAR_V)
                    bar_y_t <= bar_y_t - BAR_V;

                if (ball_x_l > X_MAX) begin
                    ball_x_l <= BALL_X_RST;
                    ball_y_t <= BALL_Y_RST;
                    vx       <= V_NEG;
                    miss_r   <= 1'b1;
                end else begin
                    vx       <= vx_nxt;
                    vy       <= vy_nxt;
                    ball_x_l <= ball_x_l + vx_nxt;
                    ball_y_t <= ball_y_t + vy_nxt;
                end
            end
        end
    end

    assign rom_row = 3'(vif.pix_y - ball_y_t);
    assign rom_col = 3'(vif.pix_x - ball_x_l);

    pong_graph_anim_rom u_rom (
        .row  (rom_row),
        .data (rom_data)
    );

    assign wall_on  = vif.pix_x >= WALL_X_L && vif.pix_x <= WALL_X_R;
    assign bar_on   = vif.pix_x >= BAR_X_L && vif.pix_x <= BAR_X_R &&
                      vif.pix_y >= bar_y_t && vif.pix_y <= bar_y_b;
    assign ball_box = vif.pix_x >= ball_x_l && vif.pix_x <= ball_x_r &&
                      vif.pix_y >= ball_y_t && vif.pix_y <= ball_y_b;
    assign ball_on  = ball_box && rom_data[~rom_col];

    always_comb begin
        rgb = RGB_BG;
        if (!vif.video_on)
            rgb = RGB_OFF;
        else if (wall_on)
            rgb = RGB_WALL;
        else if (bar_on)
            rgb = RGB_BAR;
        else if (ball_on)
            rgb = RGB_BALL;
    end

    assign vif.graph_rgb = rgb;
    assign vif.miss      = miss_r;
endmodule

// File: tb/tb_pong_graph_anim.sv
// Self-checking bench for pong_graph_anim: a frame-level reference model
// feeds an expected-state queue that is drained after every refresh tick.
module tb_pong_graph_anim;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pong_graph_anim_if vif ();

    pong_graph_anim dut (
        .clk   (clk),
        .reset (reset),
        .vif   (vif)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [9:0] bar;
        logic [9:0] bx;
        logic [9:0] by;
        logic [9:0] vx;
        logic [9:0] vy;
        logic       miss;
    } exp_t;

    exp_t sb_q[$];

    int m_bar, m_bx, m_by, m_vx, m_vy;
    int exp_misses = 0;
    int obs_misses = 0;
    logic [7:0] bm [8] = '{8'h3C, 8'h7E, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h7E, 8'h3C};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_bar = 204; m_bx = 320; m_by = 240; m_vx = 2; m_vy = 2;
    endtask

    function automatic exp_t model_snapshot(input logic miss);
        exp_t e;
        e.bar  = 10'(m_bar);
        e.bx   = 10'(m_bx);
        e.by   = 10'(m_by);
        e.vx   = 10'(m_vx);
        e.vy   = 10'(m_vy);
        e.miss = miss;
        return e;
    endfunction

    task automatic model_tick(input logic [1:0] btn, output logic miss);
        int bar0;
        bar0 = m_bar;
        miss = 1'b0;
        if (btn == 2'b10 && m_bar + 71 < 475) m_bar = m_bar + 4;
        else if (btn == 2'b01 && m_bar > 4) m_bar = m_bar - 4;
        if (m_bx > 639) begin
            m_bx = 320; m_by = 240; m_vx = -2; miss = 1'b1;
        end else begin
            if (m_by <= 1) m_vy = 2;
            else if (m_by + 7 >= 478) m_vy = -2;
            if (m_bx <= 35) m_vx = 2;
            else if (m_bx + 7 >= 600 && m_bx + 7 <= 603 &&
                     m_by + 7 >= bar0 && m_by <= bar0 + 71) m_vx = -2;
            m_bx = (m_bx + m_vx) & 1023;
            m_by = (m_by + m_vy) & 1023;
        end
    endtask

    function automatic logic [2:0] model_rgb(input int x, input int y, input logic von);
        logic [7:0] r;
        if (!von) return 3'b000;
        if (x >= 32 && x <= 35) return 3'b001;
        if (x >= 600 && x <= 603 && y >= m_bar && y <= m_bar + 71) return 3'b010;
        if (x >= m_bx && x <= m_bx + 7 && y >= m_by && y <= m_by + 7) begin
            r = bm[y - m_by];
            if (r[7 - (x - m_bx)]) return 3'b100;
        end
        return 3'b110;
    endfunction

    task automatic check_state(input string tag, input exp_t e);
        check({tag, "_bar"},  32'(dut.bar_y_t),  32'(e.bar));
        check({tag, "_bx"},   32'(dut.ball_x_l), 32'(e.bx));
        check({tag, "_by"},   32'(dut.ball_y_t), 32'(e.by));
        check({tag, "_vx"},   32'(dut.vx),       32'(e.vx));
        check({tag, "_vy"},   32'(dut.vy),       32'(e.vy));
        check({tag, "_miss"}, 32'(vif.miss),     32'(e.miss));
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        #1;
        check_state("reset", model_snapshot(1'b0));
        @(negedge clk);
        reset = 1'b0;
    endtask

    // near-miss decodes first (must not update), then the real refresh tick
    task automatic do_frame(input logic [1:0] btn);
        logic m;
        exp_t e;
        @(negedge clk);
        vif.btn = btn;
        vif.p_tick = 1'b1; vif.pix_y = 10'd481; vif.pix_x = 10'd1;
        @(negedge clk);
        vif.p_tick = 1'b0; vif.pix_x = 10'd0;
        @(negedge clk);
        vif.p_tick = 1'b1; vif.pix_y = 10'd480;
        @(negedge clk);
        vif.pix_y = 10'd481;
        model_tick(btn, m);
        sb_q.push_back(model_snapshot(m));
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check_state("frame", e);
        if (vif.miss === 1'b1) obs_misses++;
        if (e.miss) exp_misses++;
        @(negedge clk);
        vif.p_tick = 1'b0; vif.pix_y = 10'd0;
        if (e.miss) begin
            @(posedge clk);
            #1;
            check("miss_width", 32'(vif.miss), 32'd0);
        end
    endtask

    task automatic check_px(input string tag, input int x, input int y, input logic von);
        @(negedge clk);
        vif.p_tick = 1'b0;
        vif.video_on = von;
        vif.pix_x = 10'(x);
        vif.pix_y = 10'(y);
        #1;
        check(tag, 32'(vif.graph_rgb), 32'(model_rgb(x, y, von)));
        vif.video_on = 1'b1;
    endtask

    task automatic scan_objects();
        int x, y;
        check_px("px_wall", 33, 100, 1'b1);
        check_px("px_bar", 601, m_bar, 1'b1);
        check_px("px_ball", m_bx + 3, m_by + 3, 1'b1);
        check_px("px_ball_corner", m_bx, m_by, 1'b1);
        check_px("px_bg", 200, 50, 1'b1);
        check_px("px_off", 33, 100, 1'b0);
        for (int i = 0; i < 24; i++) begin
            x = m_bx - 1 + int'($urandom_range(0, 9));
            y = m_by - 1 + int'($urandom_range(0, 9));
            check_px("px_ball_area", x, y, 1'b1);
        end
        for (int i = 0; i < 12; i++) begin
            x = int'($urandom_range(0, 639));
            y = int'($urandom_range(0, 479));
            check_px("px_rand", x, y, 1'b1);
        end
    endtask

    initial begin
        int budget;
        reset = 1'b1;
        vif.p_tick = 1'b0;
        vif.video_on = 1'b1;
        vif.pix_x = 10'd0;
        vif.pix_y = 10'd0;
        vif.btn = 2'b00;
        model_reset();

        apply_reset();
        scan_objects();
        do_frame(2'b00);

        for (int i = 0; i < 5; i++) do_frame(2'b00);
        apply_reset();
        do_frame(2'b00);

        apply_reset();
        for (int i = 0; i < 60; i++) do_frame(2'b10);
        // bar parked at the bottom; the ball meets it on the way right
        for (int i = 0; i < 100; i++) do_frame(2'b10);
        scan_objects();
        for (int i = 0; i < 5; i++) do_frame(2'b11);

        apply_reset();
        budget = 300;
        while (exp_misses == 0 && budget > 0) begin
            do_frame(2'b01);
            budget--;
        end
        check("miss_seen_in_budget", 32'(exp_misses), 32'd1);
        check("miss_pulses", 32'(obs_misses), 32'(exp_misses));
        for (int i = 0; i < 5; i++) do_frame(2'b01);
        scan_objects();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout observed running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/pong_graph_anim.md
Name: pong_graph_anim

Overview:
- Animated pong graphics generator.
- Consumes the VGA sync stage outputs (pixel_x, pixel_y, video_on, p_tick) and produces graph_rgb, which the top-level rgb buffer registers.
- Holds wall, paddle and ball objects; the paddle is driven by two buttons, and the ball bounces off the top/bottom edges, the wall and the paddle.
- All object state updates once per frame, on a refresh tick.

Parameters:
- H_MAX, 640, visible width in pixels
- V_MAX, 480, visible height in pixels
- BAR_V, 4, paddle step per frame (pixels)
- BALL_V, 2, ball speed magnitude per axis per frame (pixels)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- p_tick  in  1  pixel-rate enable from sync stage
- video_on  in  1  visible-region flag
- pix_x  in  10  current pixel column
- pix_y  in  10  current pixel row
- btn  in  2  btn[0]=paddle up, btn[1]=paddle down (active-high, pre-debounced)
- miss  out  1  one-clock pulse when the ball leaves the right edge
- graph_rgb  out  3  pixel colour {r,g,b}

Behaviour:
Interface:
- One clock domain, clk. reset is asynchronous and active-high; it clears all registers immediately.

Reset state:
- bar_y_t = 204.
- ball_x_l = 320, ball_y_t = 240.
- vx = +2, vy = +2.
- miss = 0.

Refresh tick:
- refr_tick = p_tick & (pix_y == 481) & (pix_x == 0).
- Exactly one clk-wide pulse per frame. All updates below happen only on refr_tick; registers hold otherwise.

Objects:
- Wall: x 32..35, full height.
- Bar: x 600..603, y bar_y_t .. bar_y_t+71.
- Ball: 8x8, x ball_x_l .. ball_x_l+7, y ball_y_t .. ball_y_t+7.
- Ball shape is an 8x8 round-ball bitmap constant, rows 00111100, 01111110, 11111111, 11111111, 11111111, 11111111, 01111110, 00111100.
- Bitmap index: row = pix_y - ball_y_t (3 LSBs), col = pix_x - ball_x_l (3 LSBs). Bit 7 of each row is the leftmost pixel.

Paddle update:
- btn == 2'b10 and bar_y_t+71 < 479-BAR_V: bar_y_t += BAR_V.
- btn == 2'b01 and bar_y_t > BAR_V: bar_y_t -= BAR_V.
- btn == 2'b11 or 2'b00: hold.

Ball velocity:
- Evaluated from current (pre-update) position and current bar_y_t, in priority order:
  - vy: ball_y_t <= 1 gives +BALL_V; else ball_y_t+7 >= 478 gives -BALL_V; else hold.
  - vx: ball_x_l <= 35 gives +BALL_V; else if ball_x_l+7 is in 600..603 and ball_y_t+7 >= bar_y_t and ball_y_t <= bar_y_t+71, vx = -BALL_V; else hold.
- Ball position is then updated with the new velocity in the same cycle: ball_x_l += vx, ball_y_t += vy. Arithmetic is 10-bit two's complement.

Miss:
- If ball_x_l > 639 at refr_tick, position and velocity updates are skipped.
- Instead: ball_x_l = 320, ball_y_t = 240, vx = -BALL_V, vy keeps its current value, and miss pulses high for that one clk.
- miss is registered and is 0 in every other cycle.

Render (combinational from pix_x/pix_y and registers, zero latency):
- Priority: !video_on gives 000.
- Else wall: 001.
- Else bar: 010.
- Else ball pixel with bitmap bit = 1: 100.
- Else background: 110.
- A bitmap 0 inside the ball box shows background.

Reset mid-frame:
- Objects return to the reset state immediately.
- The next update occurs at the next refr_tick.

Decomposition:
- Shared package: screen limits (640/480), wall/bar x bounds, bar height 72, ball size 8, colour constants, and the ball bitmap ROM contents.
- No sub-module required. An optional pong_ball_rom (3-bit row in, 8-bit row out, combinational) keeps the bitmap reusable for the text/graphics variants.

Test Plan:
- Assert reset mid-run, release, one refr_tick with btn=00 -> bar_y_t=204, ball at (322,242), miss=0.
- Hold btn=10 for 60 frames -> bar_y_t steps by 4 and stops at 404 (bar bottom 475); no further motion on additional frames.
- Hold btn=01 from reset -> bar_y_t stops at 4; btn=11 for 5 frames -> bar_y_t unchanged.
- Place ball at y_t=470, vy=+2 (via frames from reset) -> on the frame when ball_y_t+7 >= 478, vy becomes -2 and ball_y_t decreases by 2 that same frame.
- Bar at 204, ball approaching with ball_y_t=240 and ball_x_l+7 reaching 600 -> vx flips to -2; the ball never enters x>603.
- Bar moved to top (4), ball at y 240 moving right -> ball passes x 639, miss pulses exactly one clk, ball returns to (320,240) with vx=-2. Also scan one frame, check pixel (33,100)=001, (601,bar_y_t)=010, (ball_x_l+3,ball_y_t+3)=100, (ball_x_l,ball_y_t)=110, and video_on=0 gives 000.
